// File: rtl/s4_mem_stage_pkg.sv
// Shared pipeline types for the memory stage: op encoding, FSM states, bus payloads
// and the store-lane / load-extend helpers.
package s4_mem_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RIDX = 5;
    localparam int unsigned NBE  = XLEN / 8;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic            we;
        logic [NBE-1:0]  be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dm_cmd_t;

    typedef struct packed {
        logic [RIDX-1:0] rd;
        logic [XLEN-1:0] data;
        logic            we;
        logic            fault;
    } wb_pkt_t;

    function automatic logic is_load(input mem_op_t op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return off != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [NBE-1:0] store_be(input mem_op_t op, input logic [1:0] off);
        case (op)
            OP_SB:   return NBE'(4'b0001 << off);
            OP_SH:   return NBE'(4'b0011 << off);
            OP_SW:   return '1;
            default: return '0;
        endcase
    endfunction

    // Narrow stores replicate across the word so the lane enable picks the copy.
    function automatic logic [XLEN-1:0] store_data(input mem_op_t op, input logic [XLEN-1:0] sdata);
        case (op)
            OP_SB:   return {4{sdata[7:0]}};
            OP_SH:   return {2{sdata[15:0]}};
            OP_SW:   return sdata;
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input mem_op_t op, input logic [1:0] off,
                                                     input logic [XLEN-1:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   return {{(XLEN-8){b[7]}}, b};
            OP_LBU:  return {{(XLEN-8){1'b0}}, b};
            OP_LH:   return {{(XLEN-16){h[15]}}, h};
            OP_LHU:  return {{(XLEN-16){1'b0}}, h};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/s4_load_align.sv
// Combinational load extract: selects the byte/halfword lane and sign/zero-extends it.
module s4_load_align
    import s4_mem_stage_pkg::*;
(
    input  mem_op_t         op_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_c_o
);

    always_comb begin
        data_c_o = load_extract(op_i, off_i, rdata_i);
    end

endmodule

// File: rtl/s4_mem_stage.sv
// Memory pipeline stage: issues one data-memory request per op, aligns load data and
// produces a single-cycle writeback pulse.
module s4_mem_stage
    import s4_mem_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [3:0]      ex_op,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] ex_sdata,
    input  logic [RIDX-1:0] ex_rd,
    output logic            dm_req,
    output logic            dm_we,
    output logic [XLEN-1:0] dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    output logic [NBE-1:0]  dm_be,
    input  logic            dm_gnt,
    input  logic            dm_rvalid,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            wb_valid,
    output logic [RIDX-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_we,
    output logic            wb_fault
);

    mem_state_t      state_q, state_d;
    mem_op_t         op_q, op_d;
    logic [1:0]      off_q, off_d;
    logic [RIDX-1:0] rd_q, rd_d;
    dm_cmd_t         cmd_q, cmd_d;
    wb_pkt_t         wb_q, wb_d;
    logic            ex_ready_q, ex_ready_d;
    logic            dm_req_q, dm_req_d;
    logic            wb_valid_q, wb_valid_d;

    mem_op_t         ex_op_c;
    logic [1:0]      ex_off_c;
    logic [XLEN-1:0] ld_data_c;

    assign ex_op_c  = mem_op_t'(ex_op);
    assign ex_off_c = ex_result[1:0];

    s4_load_align u_load_align (
        .op_i     (op_q),
        .off_i    (off_q),
        .rdata_i  (dm_rdata),
        .data_c_o (ld_data_c)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        off_d   = off_q;
        rd_d    = rd_q;
        cmd_d   = cmd_q;
        wb_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid && ex_ready_q) begin
                    op_d  = ex_op_c;
                    off_d = ex_off_c;
                    rd_d  = ex_rd;
                    if (!is_load(ex_op_c) && !is_store(ex_op_c)) begin
                        state_d = ST_DONE;
                        wb_d.rd   = ex_rd;
                        wb_d.data = ex_result;
                        wb_d.we   = (ex_rd != '0);
                    end else if (is_misaligned(ex_op_c, ex_off_c)) begin
                        state_d    = ST_DONE;
                        wb_d.rd    = ex_rd;
                        wb_d.fault = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        cmd_d.we    = is_store(ex_op_c);
                        cmd_d.addr  = {ex_result[XLEN-1:2], 2'b00};
                        cmd_d.be    = store_be(ex_op_c, ex_off_c);
                        cmd_d.wdata = store_data(ex_op_c, ex_sdata);
                    end
                end
            end
            ST_REQ: begin
                if (dm_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Stores also complete here: the response beat is their acknowledge.
                if (dm_rvalid) begin
                    state_d = ST_DONE;
                    wb_d.rd = rd_q;
                    if (is_load(op_q)) begin
                        wb_d.data = ld_data_c;
                        wb_d.we   = (rd_q != '0);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ex_ready_d = (state_d == ST_IDLE);
        dm_req_d   = (state_d == ST_REQ);
        wb_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NONE;
            off_q      <= '0;
            rd_q       <= '0;
            cmd_q      <= '0;
            wb_q       <= '0;
            ex_ready_q <= 1'b0;
            dm_req_q   <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            cmd_q      <= cmd_d;
            wb_q       <= wb_d;
            ex_ready_q <= ex_ready_d;
            dm_req_q   <= dm_req_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    assign ex_ready = ex_ready_q;
    assign dm_req   = dm_req_q;
    assign dm_we    = cmd_q.we;
    assign dm_addr  = cmd_q.addr;
    assign dm_wdata = cmd_q.wdata;
    assign dm_be    = cmd_q.be;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_q.rd;
    assign wb_data  = wb_q.data;
    assign wb_we    = wb_q.we;
    assign wb_fault = wb_q.fault;

endmodule

// File: tb/tb_s4_mem_stage.sv
// Self-checking bench for s4_mem_stage: directed vector table, hand-written corner
// sequences and a randomized stream checked against an arithmetic reference model.
module tb_s4_mem_stage;
    import s4_mem_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_op;
    logic [31:0] ex_result;
    logic [31:0] ex_sdata;
    logic [4:0]  ex_rd;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        wb_fault;

    int checks = 0;
    int errors = 0;

    s4_mem_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op     (ex_op),
        .ex_result (ex_result),
        .ex_sdata  (ex_sdata),
        .ex_rd     (ex_rd),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_we     (wb_we),
        .wb_fault  (wb_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        mem_op_t     op;
        logic [31:0] res;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          gnt_at;
        int          rv_dly;
        int          exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_we;
        logic        exp_fault;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: derives access size, lanes and extension from plain arithmetic.
    function automatic vec_t model(input mem_op_t op, input logic [31:0] res, input logic [31:0] sdata,
                                   input logic [4:0] rd, input logic [31:0] rdata,
                                   input int gnt_at, input int rv_dly);
        vec_t v;
        int sz;
        int ofs;
        bit ld, st, sgn;
        logic [31:0] mask, val;
        v.op = op; v.res = res; v.sdata = sdata; v.rd = rd; v.rdata = rdata;
        v.gnt_at = gnt_at; v.rv_dly = rv_dly;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = 1;
            OP_LH, OP_LHU, OP_SH: sz = 2;
            OP_LW, OP_SW:         sz = 4;
            default:              sz = 0;
        endcase
        ofs = int'(res % 32'd4);
        ld  = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
        st  = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        sgn = (op == OP_LB) || (op == OP_LH);
        v.exp_fault = (sz > 1) && ((ofs % sz) != 0);
        v.exp_req   = ((ld || st) && !v.exp_fault) ? gnt_at : 0;
        v.exp_addr  = res - (res % 32'd4);
        v.exp_be    = 4'(((1 << sz) - 1) << ofs);
        if (sz == 1)      v.exp_wdata = {24'd0, sdata[7:0]} * 32'h0101_0101;
        else if (sz == 2) v.exp_wdata = {16'd0, sdata[15:0]} * 32'h0001_0001;
        else              v.exp_wdata = sdata;
        if (ld) begin
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
            val  = (rdata >> (8 * ofs)) & mask;
            if (sgn && val[8 * sz - 1]) val = val | ~mask;
            v.exp_data = val;
        end else if (st) begin
            v.exp_data = 32'd0;
        end else begin
            v.exp_data = res;
        end
        v.exp_we = !v.exp_fault && !st && (rd != 5'd0);
        return v;
    endfunction

    // Drives one op through the stage, acting as the memory responder.
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int req_cnt;
        bit st, bad_cmd, bad_wait;
        st = (v.op == OP_SB) || (v.op == OP_SH) || (v.op == OP_SW);
        n = 0;
        while (!ex_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready"}, 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_op = v.op; ex_result = v.res; ex_sdata = v.sdata; ex_rd = v.rd;
        @(negedge clk);
        ex_valid = 1'b0; ex_op = 4'($urandom); ex_result = $urandom; ex_sdata = $urandom; ex_rd = 5'($urandom);
        chk({tag, ".busy"}, 32'(ex_ready), 32'd0);
        req_cnt = 0;
        bad_cmd = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!dm_req) break;
            req_cnt++;
            if (dm_addr !== v.exp_addr || dm_we !== st) bad_cmd = 1'b1;
            if (st && (dm_be !== v.exp_be || dm_wdata !== v.exp_wdata)) bad_cmd = 1'b1;
            if (req_cnt == v.gnt_at) dm_gnt = 1'b1;
            @(negedge clk);
            dm_gnt = 1'b0;
        end
        chk({tag, ".req_cycles"}, 32'(req_cnt), 32'(v.exp_req));
        if (v.exp_req != 0) begin
            chk({tag, ".cmd"}, 32'(bad_cmd), 32'd0);
            bad_wait = 1'b0;
            for (int k = 0; k < v.rv_dly; k++) begin
                if (wb_valid) bad_wait = 1'b1;
                @(negedge clk);
            end
            chk({tag, ".early_wb"}, 32'(bad_wait), 32'd0);
            dm_rvalid = 1'b1; dm_rdata = v.rdata;
            @(negedge clk);
            dm_rvalid = 1'b0; dm_rdata = $urandom;
        end
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, ".wb_fault"}, 32'(wb_fault), 32'(v.exp_fault));
        chk({tag, ".wb_we"}, 32'(wb_we), 32'(v.exp_we));
        if (!st && !v.exp_fault) begin
            chk({tag, ".wb_data"}, wb_data, v.exp_data);
            chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
        end
        @(negedge clk);
        chk({tag, ".wb_pulse"}, 32'(wb_valid), 32'd0);
        chk({tag, ".ready_back"}, 32'(ex_ready), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ctl"}, 32'({ex_ready, dm_req, dm_we, dm_be, wb_valid, wb_we, wb_fault, wb_rd}), 32'd0);
        chk({tag, ".data"}, dm_addr | dm_wdata | wb_data, 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        vec_t v;
        int bad;
        rst_n = 1'b0; ex_valid = 1'b0; ex_op = 4'd0; ex_result = '0; ex_sdata = '0; ex_rd = '0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;

        //           op      result        sdata         rd     rdata        g  rv req addr          be       wdata         wb_data       we    fault
        vecs[0]  = '{OP_NONE, 32'h1234_5678, 32'h0,        5'd3,  32'h0,        1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h1234_5678, 1'b1, 1'b0};
        vecs[1]  = '{OP_SB,   32'h0000_0102, 32'h1234_56AB, 5'd9,  32'h0,        3, 1, 3, 32'h0000_0100, 4'b0100, 32'hABAB_ABAB, 32'h0,        1'b0, 1'b0};
        vecs[2]  = '{OP_LB,   32'h0000_0103, 32'h0,        5'd5,  32'h80FF_FFFF, 1, 0, 1, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b1, 1'b0};
        vecs[3]  = '{OP_LBU,  32'h0000_0103, 32'h0,        5'd5,  32'h80FF_FFFF, 2, 2, 2, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080, 1'b1, 1'b0};
        vecs[4]  = '{OP_LW,   32'h0000_0202, 32'h0,        5'd4,  32'h0,        1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 1'b1};
        vecs[5]  = '{OP_LH,   32'h0000_0002, 32'h0,        5'd0,  32'h8001_0000, 1, 0, 1, 32'h0000_0000, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0};
        vecs[6]  = '{OP_SH,   32'h0000_0012, 32'h5555_BEEF, 5'd1,  32'h0,        1, 0, 1, 32'h0000_0010, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{OP_SW,   32'h0000_0020, 32'hDEAD_BEEF, 5'd2,  32'h0,        2, 1, 2, 32'h0000_0020, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{OP_LHU,  32'h0000_0000, 32'h0,        5'd31, 32'h1234_ABCD, 1, 3, 1, 32'h0000_0000, 4'b0000, 32'h0,        32'h0000_ABCD, 1'b1, 1'b0};
        vecs[9]  = '{OP_SH,   32'h0000_0013, 32'h0000_1111, 5'd6,  32'h0,        1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 1'b1};
        vecs[10] = '{OP_NONE, 32'h0000_0005, 32'h0,        5'd0,  32'h0,        1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0000_0005, 1'b0, 1'b0};
        vecs[11] = '{OP_LW,   32'hFFFF_FF44, 32'h0,        5'd17, 32'hCAFE_F00D, 1, 0, 1, 32'hFFFF_FF44, 4'b0000, 32'h0,        32'hCAFE_F00D, 1'b1, 1'b0};

        // Reset state, then ready only after the first clock following release.
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.ready_low", 32'(ex_ready), 32'd0);
        @(negedge clk);
        chk("rel.ready_high", 32'(ex_ready), 32'd1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Stray response beat while idle is ignored.
        dm_rvalid = 1'b1; dm_rdata = 32'h1111_2222;
        @(negedge clk);
        dm_rvalid = 1'b0;
        chk("stray.wb_valid", 32'(wb_valid), 32'd0);
        chk("stray.ready", 32'(ex_ready), 32'd1);

        // ex_valid held high: second op is not taken from DONE.
        ex_valid = 1'b1; ex_op = OP_NONE; ex_result = 32'hAAAA_0001; ex_rd = 5'd8;
        @(negedge clk);
        ex_result = 32'hBBBB_0002;
        chk("b2b.first_valid", 32'(wb_valid), 32'd1);
        chk("b2b.first_data", wb_data, 32'hAAAA_0001);
        @(negedge clk);
        chk("b2b.gap", 32'(wb_valid), 32'd0);
        chk("b2b.gap_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("b2b.second_valid", 32'(wb_valid), 32'd1);
        chk("b2b.second_data", wb_data, 32'hBBBB_0002);
        @(negedge clk);

        // Reset while waiting for the response abandons the load.
        ex_valid = 1'b1; ex_op = OP_LW; ex_result = 32'h0000_0040; ex_rd = 5'd7;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rstw.req", 32'(dm_req), 32'd1);
        dm_gnt = 1'b1;
        @(negedge clk);
        dm_gnt = 1'b0;
        chk("rstw.in_wait", 32'(dm_req), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstw");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        dm_rvalid = 1'b1; dm_rdata = 32'h7777_7777;
        @(negedge clk);
        dm_rvalid = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (wb_valid) bad++;
            @(negedge clk);
        end
        chk("rstw.no_wb", 32'(bad), 32'd0);
        chk("rstw.ready", 32'(ex_ready), 32'd1);

        // Randomized stream against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
            v = model(mem_op_t'(4'($urandom_range(0, 8))), a, $urandom,
                      ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), $urandom,
                      $urandom_range(1, 3), $urandom_range(0, 2));
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
